// File: rtl/serial_adder.sv
// Digit-serial adder: one DIGIT-bit slice reused STEPS times through a registered
// carry, with valid/ready handshakes on operands and result.
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int STEPS = WIDTH / DIGIT;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

   generate
      if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
         $error("serial_adder: DIGIT must divide WIDTH and WIDTH must be >= 2");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic             carry;
   logic [WIDTH-1:0] a_sr, b_sr;
   logic [DIGIT:0]   dsum;
   logic             c_msb;
   logic [WIDTH-1:0] sum_nxt;

   always_comb begin
      dsum  = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
      // carry into the slice MSB recovered from that bit's sum: s = a ^ b ^ c_in
      c_msb = dsum[DIGIT-1] ^ a_sr[DIGIT-1] ^ b_sr[DIGIT-1];
   end

   generate
      if (DIGIT == WIDTH) begin : g_one_step
         assign sum_nxt = dsum[DIGIT-1:0];
      end else begin : g_multi_step
         assign sum_nxt = {dsum[DIGIT-1:0], sum[WIDTH-1:DIGIT]};
      end
   endgenerate

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
         carry <= 1'b0;
         a_sr  <= '0;
         b_sr  <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  carry <= cin;
                  count <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               sum   <= sum_nxt;
               carry <= dsum[DIGIT];
               a_sr  <= a_sr >> DIGIT;
               b_sr  <= b_sr >> DIGIT;
               count <= count + CW'(1);
               if (count == CW'(STEPS - 1)) begin
                  cout  <= dsum[DIGIT];
                  ovf   <= c_msb ^ dsum[DIGIT];
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: 8/1 instance driven from a vector table and a scoreboard,
// plus 16/4 and 8/8 instances for the wider-digit cases.
module tb_serial_adder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int asserts = 0;
   int fails   = 0;

   // WIDTH=8, DIGIT=1
   logic       v8 = 0, r8, ov8, or8 = 0, cin8 = 0, co8, ovf8;
   logic [7:0] a8 = 0, b8 = 0, s8;
   serial_adder #(.WIDTH(8), .DIGIT(1)) u8 (
      .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .a(a8), .b(b8), .cin(cin8),
      .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .ovf(ovf8));

   // WIDTH=16, DIGIT=4
   logic        v16 = 0, r16, ov16, or16 = 0, cin16 = 0, co16, ovf16;
   logic [15:0] a16 = 0, b16 = 0, s16;
   serial_adder #(.WIDTH(16), .DIGIT(4)) u16 (
      .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16), .a(a16), .b(b16), .cin(cin16),
      .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16), .ovf(ovf16));

   // WIDTH=8, DIGIT=8 (single RUN cycle)
   logic       vd = 0, rd, ovd, ord = 0, cind = 0, cod, ovfd;
   logic [7:0] ad = 0, bd = 0, sd;
   serial_adder #(.WIDTH(8), .DIGIT(8)) ud (
      .clk(clk), .rst(rst), .in_valid(vd), .in_ready(rd), .a(ad), .b(bd), .cin(cind),
      .out_valid(ovd), .out_ready(ord), .sum(sd), .cout(cod), .ovf(ovfd));

   typedef struct packed {
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } res_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      res_t       exp;
   } vec_t;

   res_t sb[$];

   function automatic res_t model8(input logic [7:0] a, input logic [7:0] b, input logic cin);
      logic [8:0] full;
      logic [7:0] low;
      res_t       r;
      full   = {1'b0, a} + {1'b0, b} + {8'd0, cin};
      low    = {1'b0, a[6:0]} + {1'b0, b[6:0]} + {7'd0, cin};
      r.sum  = full[7:0];
      r.cout = full[8];
      r.ovf  = low[7] ^ full[8];
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      asserts++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic cin, input res_t e);
      int n = 0;
      while (!r8 && n < 30) begin tick; n++; end
      check("in_ready_before_accept", r8, 1);
      a8 = a; b8 = b; cin8 = cin; v8 = 1;
      sb.push_back(e);
      tick;
      v8 = 0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
   endtask

   task automatic finish8;
      int   n = 0;
      res_t e;
      while (!ov8 && n < 20) begin tick; n++; end
      check("latency8", n, 8);
      if (sb.size() == 0) begin
         check("scoreboard_nonempty", 0, 1);
      end else begin
         e = sb.pop_front();
         check("sum8", s8, e.sum);
         check("cout8", co8, e.cout);
         check("ovf8", ovf8, e.ovf);
      end
   endtask

   task automatic ack8;
      or8 = 1; tick; or8 = 0;
   endtask

   // which: 0 = 16/4 instance, 1 = 8/8 instance
   task automatic run_w(input int which, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [15:0] es, input logic ec,
                        input logic eo, input int lat);
      int n = 0;
      if (which == 0) begin
         a16 = a; b16 = b; cin16 = cin; v16 = 1; tick; v16 = 0; a16 = '1;
         while (!ov16 && n < 20) begin tick; n++; end
         check("latency16", n, lat);
         check("sum16", s16, es);
         check("cout16", co16, ec);
         check("ovf16", ovf16, eo);
         or16 = 1; tick; or16 = 0;
      end else begin
         ad = a[7:0]; bd = b[7:0]; cind = cin; vd = 1; tick; vd = 0; ad = '1;
         while (!ovd && n < 20) begin tick; n++; end
         check("latency_d8", n, lat);
         check("sum_d8", sd, es);
         check("cout_d8", cod, ec);
         check("ovf_d8", ovfd, eo);
         ord = 1; tick; ord = 0;
      end
   endtask

   vec_t vt[8];
   logic [7:0] pa[3], pb[3];
   int acc[3];

   initial begin
      vt[0] = '{8'h3C, 8'h5A, 1'b0, '{8'h96, 1'b0, 1'b1}};
      vt[1] = '{8'hFF, 8'h01, 1'b0, '{8'h00, 1'b1, 1'b0}};
      vt[2] = '{8'hFF, 8'hFF, 1'b1, '{8'hFF, 1'b1, 1'b0}};
      vt[3] = '{8'h80, 8'h80, 1'b0, '{8'h00, 1'b1, 1'b1}};
      vt[4] = '{8'h7F, 8'h00, 1'b1, '{8'h80, 1'b0, 1'b1}};
      vt[5] = '{8'h10, 8'h20, 1'b0, '{8'h30, 1'b0, 1'b0}};
      vt[6] = '{8'h00, 8'h00, 1'b0, '{8'h00, 1'b0, 1'b0}};
      vt[7] = '{8'h55, 8'hAA, 1'b1, '{8'h00, 1'b1, 1'b0}};

      // reset state
      #2;
      check("rst_out_valid", ov8, 0);
      check("rst_in_ready", r8, 1);
      check("rst_sum", s8, 0);
      check("rst_cout", co8, 0);
      check("rst_ovf", ovf8, 0);
      repeat (2) @(negedge clk);
      rst = 0;
      tick;

      foreach (vt[i]) begin
         start8(vt[i].a, vt[i].b, vt[i].cin, vt[i].exp);
         finish8;
         ack8;
      end

      for (int i = 0; i < 6; i++) begin
         logic [7:0] ra, rb;
         logic       rc;
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
         start8(ra, rb, rc, model8(ra, rb, rc));
         finish8;
         ack8;
      end

      // backpressure with inputs toggling
      start8(8'h3C, 8'h5A, 1'b0, '{8'h96, 1'b0, 1'b1});
      finish8;
      for (int i = 0; i < 5; i++) begin
         v8 = ~v8; a8 = 8'($urandom); b8 = 8'($urandom);
         tick;
         check("bp_valid", ov8, 1);
         check("bp_in_ready", r8, 0);
         check("bp_sum", s8, 8'h96);
         check("bp_cout", co8, 0);
         check("bp_ovf", ovf8, 1);
      end
      v8 = 1; or8 = 1; tick; or8 = 0;
      check("bp_release_in_ready", r8, 1);
      check("bp_release_valid", ov8, 0);
      v8 = 0;
      tick;

      // asynchronous reset in the middle of RUN
      start8(8'h3C, 8'h5A, 1'b0, '{8'h96, 1'b0, 1'b1});
      repeat (3) tick;
      #2 rst = 1;
      #1;
      check("midrst_valid", ov8, 0);
      check("midrst_sum", s8, 0);
      check("midrst_in_ready", r8, 1);
      sb.delete();
      @(negedge clk) rst = 0;
      tick;
      check("post_rst_valid", ov8, 0);
      start8(8'h10, 8'h20, 1'b0, '{8'h30, 1'b0, 1'b0});
      finish8;
      ack8;

      // back-to-back with in_valid and out_ready held
      pa[0] = 8'h3C; pb[0] = 8'h5A;
      pa[1] = 8'h7F; pb[1] = 8'h01;
      pa[2] = 8'hC3; pb[2] = 8'h81;
      begin
         int k = 0, got = 0;
         res_t e;
         a8 = pa[0]; b8 = pb[0]; cin8 = 0; v8 = 1; or8 = 1;
         for (int t = 0; t < 60 && got < 3; t++) begin
            if (ov8) begin
               e = sb.pop_front();
               check("b2b_sum", s8, e.sum);
               check("b2b_cout", co8, e.cout);
               check("b2b_ovf", ovf8, e.ovf);
               got++;
            end
            if (r8 && v8 && k < 3) begin
               acc[k] = cyc;
               sb.push_back(model8(pa[k], pb[k], 1'b0));
               k++;
            end else if (!r8) begin
               if (k < 3) begin a8 = pa[k]; b8 = pb[k]; end
               else v8 = 0;
            end
            tick;
         end
         v8 = 0; or8 = 0;
         check("b2b_results", got, 3);
         check("b2b_accept1", acc[1] - acc[0], 10);
         check("b2b_accept2", acc[2] - acc[0], 20);
      end

      // wider digits
      run_w(0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 4);
      run_w(0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 4);
      run_w(0, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 4);
      run_w(1, 16'h003C, 16'h005A, 1'b0, 16'h0096, 1'b0, 1'b1, 1);
      run_w(1, 16'h0080, 16'h0080, 1'b0, 16'h0000, 1'b1, 1'b1, 1);
      run_w(1, 16'h00FF, 16'h00FF, 1'b1, 16'h00FF, 1'b1, 1'b0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
